// File: rtl/softex_pkg.sv
// Shared types and constants for the softex datapath initiators.
package softex_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoadScal,
        StIssue,
        StDrain
    } issuer_state_t;

    localparam logic ISSUER_TAG_LAST = 1'b1;

endpackage

// File: rtl/softex_credit_counter.sv
// Saturating in-flight beat counter: +1 per issue, -1 per answer, bounded to [0, MAX].
module softex_credit_counter #(
    parameter int unsigned MAX = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CntW = $clog2(MAX + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CntW'(MAX));
    assign empty_o = (cnt_q == '0);

    // Simultaneous inc and dec cancel, even at the bounds.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/softex_addmul_issuer.sv
// Job-level initiator for one add/mul channel: latches the scalar, streams vector beats with
// strobes and a last tag under credit control, and forwards results with a done pulse.
module softex_addmul_issuer
    import softex_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned VECT_WIDTH      = 1,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [CNT_WIDTH-1:0]        len_i,
    output logic                        busy_o,
    output logic                        done_o,
    input  logic                        scal_valid_i,
    output logic                        scal_ready_o,
    input  logic [WIDTH-1:0]            scal_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [VECT_WIDTH*WIDTH-1:0] in_data_i,
    output logic                        req_valid_o,
    output logic                        req_scal_valid_o,
    input  logic                        req_ready_i,
    output logic [VECT_WIDTH-1:0]       req_strb_o,
    output logic [VECT_WIDTH*WIDTH-1:0] req_vect_o,
    output logic [WIDTH-1:0]            req_scal_o,
    output logic                        req_tag_o,
    input  logic                        rsp_valid_i,
    output logic                        rsp_ready_o,
    input  logic [VECT_WIDTH-1:0]       rsp_strb_i,
    input  logic [VECT_WIDTH*WIDTH-1:0] rsp_res_i,
    input  logic                        rsp_tag_i,
    output logic                        out_valid_o,
    output logic                        out_last_o,
    input  logic                        out_ready_i,
    output logic [VECT_WIDTH-1:0]       out_strb_o,
    output logic [VECT_WIDTH*WIDTH-1:0] out_data_o
);

    localparam int unsigned VwLog = $clog2(VECT_WIDTH);

    issuer_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]   beats_q, beats_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]       scal_q, scal_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   len_rem;
    logic [VECT_WIDTH-1:0]  strb_last;
    logic                   credit_full, unused_credit_empty;
    logic                   credit_ok, last_beat, req_hs, rsp_hs;

    assign len_rem   = len_i & CNT_WIDTH'(VECT_WIDTH - 1);
    assign credit_ok = ~credit_full;
    assign last_beat = (beats_q == CNT_WIDTH'(1));
    assign req_hs    = (state_q == StIssue) & in_valid_i & req_ready_i & credit_ok;
    assign rsp_hs    = rsp_valid_i & out_ready_i;

    softex_credit_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_credit (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .inc_i   (req_hs),
        .dec_i   (rsp_hs),
        .full_o  (credit_full),
        .empty_o (unused_credit_empty)
    );

    always_comb begin
        strb_last = '0;
        for (int i = 0; i < VECT_WIDTH; i++) begin
            strb_last[i] = (CNT_WIDTH'(i) < rem_q);
        end
    end

    always_comb begin
        state_d          = state_q;
        beats_d          = beats_q;
        rem_d            = rem_q;
        scal_d           = scal_q;
        done_d           = 1'b0;
        scal_ready_o     = 1'b0;
        in_ready_o       = 1'b0;
        req_valid_o      = 1'b0;
        req_scal_valid_o = 1'b0;
        req_strb_o       = '0;
        req_tag_o        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        beats_d = (len_i >> VwLog) + CNT_WIDTH'(len_rem != '0);
                        rem_d   = len_rem;
                        state_d = StLoadScal;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StLoadScal: begin
                scal_ready_o = 1'b1;
                if (scal_valid_i) begin
                    scal_d  = scal_i;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                req_scal_valid_o = 1'b1;
                req_valid_o      = in_valid_i & credit_ok;
                in_ready_o       = req_ready_i & credit_ok;
                req_tag_o        = last_beat ? ISSUER_TAG_LAST : ~ISSUER_TAG_LAST;
                req_strb_o       = (last_beat && rem_q != '0) ? strb_last : '1;
                if (req_hs) begin
                    beats_d = beats_q - CNT_WIDTH'(1);
                    if (last_beat) begin
                        // A zero-latency datapath can retire the last beat in the issue cycle.
                        if (rsp_hs && rsp_tag_i == ISSUER_TAG_LAST) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                req_scal_valid_o = 1'b1;
                if (rsp_hs && rsp_tag_i == ISSUER_TAG_LAST) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q <= StIdle;
            beats_q <= '0;
            rem_q   <= '0;
            scal_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            rem_q   <= rem_d;
            scal_q  <= scal_d;
            done_q  <= done_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign req_vect_o  = in_data_i;
    assign req_scal_o  = scal_q;
    assign out_valid_o = rsp_valid_i;
    assign rsp_ready_o = out_ready_i;
    assign out_strb_o  = rsp_strb_i;
    assign out_data_o  = rsp_res_i;
    assign out_last_o  = rsp_tag_i;

endmodule

// File: tb/tb_softex_addmul_issuer.sv
// Directed bench for softex_addmul_issuer with VECT_WIDTH=4 and MAX_OUTSTANDING=2.
module tb_softex_addmul_issuer;

    logic        clk_i = 1'b0;
    logic        rst_ni, clear_i, start_i;
    logic [15:0] len_i;
    logic        busy_o, done_o;
    logic        scal_valid_i, scal_ready_o;
    logic [15:0] scal_i;
    logic        in_valid_i, in_ready_o;
    logic [63:0] in_data_i;
    logic        req_valid_o, req_scal_valid_o, req_ready_i;
    logic [3:0]  req_strb_o;
    logic [63:0] req_vect_o;
    logic [15:0] req_scal_o;
    logic        req_tag_o;
    logic        rsp_valid_i, rsp_ready_o;
    logic [3:0]  rsp_strb_i;
    logic [63:0] rsp_res_i;
    logic        rsp_tag_i;
    logic        out_valid_o, out_last_o, out_ready_i;
    logic [3:0]  out_strb_o;
    logic [63:0] out_data_o;

    always #5 clk_i = ~clk_i;

    softex_addmul_issuer #(
        .WIDTH           (16),
        .VECT_WIDTH      (4),
        .MAX_OUTSTANDING (2),
        .CNT_WIDTH       (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .len_i            (len_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .scal_valid_i     (scal_valid_i),
        .scal_ready_o     (scal_ready_o),
        .scal_i           (scal_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_data_i        (in_data_i),
        .req_valid_o      (req_valid_o),
        .req_scal_valid_o (req_scal_valid_o),
        .req_ready_i      (req_ready_i),
        .req_strb_o       (req_strb_o),
        .req_vect_o       (req_vect_o),
        .req_scal_o       (req_scal_o),
        .req_tag_o        (req_tag_o),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_ready_o      (rsp_ready_o),
        .rsp_strb_i       (rsp_strb_i),
        .rsp_res_i        (rsp_res_i),
        .rsp_tag_i        (rsp_tag_i),
        .out_valid_o      (out_valid_o),
        .out_last_o       (out_last_o),
        .out_ready_i      (out_ready_i),
        .out_strb_o       (out_strb_o),
        .out_data_o       (out_data_o)
    );

    // Responder: mode 0 answers combinationally, mode 1 queues and answers while rsp_en is set.
    bit          rsp_mode, rsp_en, rnd_mode;
    logic [63:0] fq_data [16];
    logic [3:0]  fq_strb [16];
    logic        fq_tag  [16];
    int          wp = 0, rp = 0;

    always_comb begin
        if (!rsp_mode) begin
            rsp_valid_i = req_valid_o & req_ready_i;
            rsp_res_i   = req_vect_o;
            rsp_strb_i  = req_strb_o;
            rsp_tag_i   = req_tag_o;
        end else begin
            rsp_valid_i = rsp_en && (wp != rp);
            rsp_res_i   = fq_data[rp % 16];
            rsp_strb_i  = fq_strb[rp % 16];
            rsp_tag_i   = fq_tag[rp % 16];
        end
    end

    always @(posedge clk_i) begin
        if (rsp_mode && req_valid_o && req_ready_i) begin
            fq_data[wp % 16] <= req_vect_o;
            fq_strb[wp % 16] <= req_strb_o;
            fq_tag[wp % 16]  <= req_tag_o;
            wp <= wp + 1;
        end
        if (rsp_mode && rsp_valid_i && rsp_ready_o) rp <= rp + 1;
    end

    // Monitor logs every handshake and tracks in-flight beats.
    int          n_req = 0, n_rsp = 0, n_out = 0, n_done = 0;
    logic [3:0]  strb_log [128];
    logic        tag_log  [128];
    logic [63:0] odat_log [128];
    logic        olast_log[128];
    bit          ovf = 1'b0;

    always @(posedge clk_i) begin
        if (req_valid_o && req_ready_i && n_req < 128) begin
            strb_log[n_req] <= req_strb_o;
            tag_log[n_req]  <= req_tag_o;
            n_req <= n_req + 1;
        end
        if (rsp_valid_i && rsp_ready_o) n_rsp <= n_rsp + 1;
        if (out_valid_o && out_ready_i && n_out < 128) begin
            odat_log[n_out]  <= out_data_o;
            olast_log[n_out] <= out_last_o;
            n_out <= n_out + 1;
        end
        if (done_o) n_done <= n_done + 1;
        if (n_req - n_rsp > 2) ovf <= 1'b1;
    end

    int n_cmp = 0, n_err = 0;
    int rb, ob, db;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_val(input int k);
        logic [15:0] b;
        b = 16'(4 * k) + 16'hA000;
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rnd_mode) begin
            req_ready_i = 1'($urandom_range(0, 1));
            out_ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic mark();
        rb = n_req;
        ob = n_out;
        db = n_done;
    endtask

    task automatic start_job(input int len);
        start_i = 1'b1;
        len_i   = 16'(len);
        tick();
        start_i = 1'b0;
    endtask

    task automatic load_scal(input logic [15:0] val);
        bit hs = 1'b0;
        scal_valid_i = 1'b1;
        scal_i       = val;
        for (int c = 0; c < 50 && !hs; c++) begin
            #1;
            hs = scal_ready_o;
            tick();
        end
        scal_valid_i = 1'b0;
        check("scal_handshake", 64'(hs), 64'd1);
    endtask

    task automatic send_beat(input logic [63:0] data);
        bit hs = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = data;
        for (int c = 0; c < 300 && !hs; c++) begin
            #1;
            hs = in_ready_o;
            tick();
        end
        in_valid_i = 1'b0;
        check("beat_handshake", 64'(hs), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && n_done == db; c++) tick();
        check("done_seen", 64'(n_done != db), 64'd1);
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
        scal_valid_i = 1'b0; scal_i = '0; in_valid_i = 1'b0; in_data_i = '0;
        req_ready_i = 1'b1; out_ready_i = 1'b1;
        rsp_mode = 1'b0; rsp_en = 1'b0; rnd_mode = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_scal_ready", 64'(scal_ready_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_req_valid", 64'(req_valid_o), 64'd0);
        check("rst_req_scal_valid", 64'(req_scal_valid_o), 64'd0);
        check("rst_req_tag_strb", {59'd0, req_tag_o, req_strb_o}, 64'd0);
        check("rst_req_scal", 64'(req_scal_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // len=10 with zero-latency responder
        mark();
        start_job(10);
        @(negedge clk_i);
        check("t1_scal_ready", 64'(scal_ready_o), 64'd1);
        check("t1_busy", 64'(busy_o), 64'd1);
        load_scal(16'h3C00);
        @(negedge clk_i);
        check("t1_req_scal", 64'(req_scal_o), 64'h3C00);
        check("t1_req_scal_valid", 64'(req_scal_valid_o), 64'd1);
        for (int k = 0; k < 3; k++) send_beat(beat_val(k));
        wait_done(50);
        repeat (3) tick();
        @(negedge clk_i);
        check("t1_n_req", 64'(n_req - rb), 64'd3);
        check("t1_strb", {52'd0, strb_log[rb], strb_log[rb+1], strb_log[rb+2]}, 64'hFF3);
        check("t1_tag", {61'd0, tag_log[rb], tag_log[rb+1], tag_log[rb+2]}, 64'b001);
        check("t1_n_out", 64'(n_out - ob), 64'd3);
        check("t1_last", {61'd0, olast_log[ob], olast_log[ob+1], olast_log[ob+2]}, 64'b001);
        check("t1_out_data2", odat_log[ob+2], beat_val(2));
        check("t1_done_count", 64'(n_done - db), 64'd1);
        check("t1_busy_end", 64'(busy_o), 64'd0);

        // len=0: immediate done
        mark();
        start_job(0);
        @(negedge clk_i);
        check("t2_done", 64'(done_o), 64'd1);
        check("t2_busy", 64'(busy_o), 64'd0);
        check("t2_scal_ready", 64'(scal_ready_o), 64'd0);
        tick();
        @(negedge clk_i);
        check("t2_done_low", 64'(done_o), 64'd0);
        check("t2_done_count", 64'(n_done - db), 64'd1);

        // Credit limit with a responder that holds its answers
        rsp_mode = 1'b1;
        rsp_en   = 1'b0;
        mark();
        start_job(16);
        load_scal(16'h1234);
        send_beat(beat_val(0));
        send_beat(beat_val(1));
        in_valid_i = 1'b1;
        in_data_i  = beat_val(2);
        repeat (2) tick();
        @(negedge clk_i);
        check("t3_n_req_full", 64'(n_req - rb), 64'd2);
        check("t3_in_ready_full", 64'(in_ready_o), 64'd0);
        check("t3_req_valid_full", 64'(req_valid_o), 64'd0);
        rsp_en = 1'b1;
        tick();
        rsp_en = 1'b0;
        repeat (3) tick();
        @(negedge clk_i);
        check("t3_n_req_one_more", 64'(n_req - rb), 64'd3);
        check("t3_in_ready_again", 64'(in_ready_o), 64'd0);
        in_valid_i = 1'b0;
        rsp_en     = 1'b1;
        send_beat(beat_val(3));
        db = n_done;
        wait_done(50);
        repeat (2) tick();
        @(negedge clk_i);
        check("t3_n_out", 64'(n_out - ob), 64'd4);
        check("t3_last", 64'(olast_log[ob+3]), 64'd1);

        // len=37 under random backpressure
        mark();
        rnd_mode = 1'b1;
        start_job(37);
        load_scal(16'h4000);
        for (int k = 0; k < 10; k++) send_beat(beat_val(k));
        wait_done(500);
        rnd_mode    = 1'b0;
        req_ready_i = 1'b1;
        out_ready_i = 1'b1;
        repeat (3) tick();
        @(negedge clk_i);
        check("t4_n_out", 64'(n_out - ob), 64'd10);
        for (int k = 0; k < 10; k++) check($sformatf("t4_data%0d", k), odat_log[ob+k], beat_val(k));
        check("t4_last9", 64'(olast_log[ob+9]), 64'd1);
        check("t4_last8", 64'(olast_log[ob+8]), 64'd0);
        check("t4_strb_last", 64'(strb_log[rb+9]), 64'h1);
        check("t4_strb_8", 64'(strb_log[rb+8]), 64'hF);
        check("t4_no_overflow", 64'(ovf), 64'd0);
        check("t4_done_count", 64'(n_done - db), 64'd1);
        rsp_en = 1'b0;

        // clear mid-ISSUE, then a normal len=4 job
        rsp_mode = 1'b0;
        mark();
        start_job(16);
        load_scal(16'h5555);
        send_beat(beat_val(0));
        send_beat(beat_val(1));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        @(negedge clk_i);
        check("t5_busy_after_clear", 64'(busy_o), 64'd0);
        check("t5_done_after_clear", 64'(done_o), 64'd0);
        check("t5_req_scal_cleared", 64'(req_scal_o), 64'd0);
        repeat (3) tick();
        @(negedge clk_i);
        check("t5_no_done", 64'(n_done - db), 64'd0);
        mark();
        start_job(4);
        load_scal(16'h3C00);
        send_beat(beat_val(7));
        wait_done(50);
        @(negedge clk_i);
        check("t5_new_strb", 64'(strb_log[rb]), 64'hF);
        check("t5_new_last", 64'(olast_log[ob]), 64'd1);
        check("t5_new_data", odat_log[ob], beat_val(7));

        // start during DRAIN is ignored
        rsp_mode = 1'b1;
        rsp_en   = 1'b0;
        repeat (2) tick();
        mark();
        start_job(4);
        load_scal(16'h3C00);
        send_beat(beat_val(0));
        @(negedge clk_i);
        check("t6_busy_drain", 64'(busy_o), 64'd1);
        check("t6_scal_valid_drain", 64'(req_scal_valid_o), 64'd1);
        start_job(8);
        rsp_en = 1'b1;
        wait_done(50);
        repeat (4) tick();
        @(negedge clk_i);
        check("t6_done_count", 64'(n_done - db), 64'd1);
        check("t6_busy_end", 64'(busy_o), 64'd0);
        check("t6_scal_ready", 64'(scal_ready_o), 64'd0);
        check("t6_n_req", 64'(n_req - rb), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/softex_addmul_issuer.md
# softex_addmul_issuer

Job-level initiator for the vector add/mul datapath. It latches one scalar operand per job, streams `len_i` elements of vector data toward the add/mul unit with correct strobes and last-beat tags, and bounds in-flight beats with a credit counter. It also forwards results downstream with a `last` flag and pulses `done_o` when the job has fully retired. It sits between the streamer/controller and one add or mul channel of the datapath.

## Interface
Parameters:
- `WIDTH`, 16: element width (bits), taken from the FP format.
- `VECT_WIDTH`, 1: elements per beat. Must be a power of two.
- `MAX_OUTSTANDING`, 8: maximum beats issued but not yet answered.
- `CNT_WIDTH`, 16: width of the job length counter.

Ports:
- `clk_i` in 1: clock (single clock domain).
- `rst_ni` in 1: reset, synchronous, active-low.
- `clear_i` in 1: synchronous soft clear.
- `start_i` in 1: job start pulse. Samples `len_i`.
- `len_i` in CNT_WIDTH: element count of the job.
- `busy_o` out 1: job in progress.
- `done_o` out 1: one-cycle job-complete pulse.
- `scal_valid_i` / `scal_ready_o` / `scal_i` in/out/in, 1/1/WIDTH: scalar operand handshake.
- `in_valid_i` / `in_ready_o` / `in_data_i` in/out/in, 1/1/VECT_WIDTH*WIDTH: vector stream.
- `req_valid_o`, `req_scal_valid_o` out 1: request to the datapath.
- `req_ready_i` in 1.
- `req_strb_o` out VECT_WIDTH.
- `req_vect_o` out VECT_WIDTH*WIDTH.
- `req_scal_o` out WIDTH.
- `req_tag_o` out 1: last-beat tag.
- `rsp_valid_i` in 1, `rsp_ready_o` out 1, `rsp_strb_i` in VECT_WIDTH, `rsp_res_i` in VECT_WIDTH*WIDTH, `rsp_tag_i` in 1: results from the datapath.
- `out_valid_o`, `out_last_o` out 1; `out_ready_i` in 1; `out_strb_o` out VECT_WIDTH; `out_data_o` out VECT_WIDTH*WIDTH: result stream.

## Operation
- FSM states: IDLE, LOAD_SCAL, ISSUE, DRAIN.
- IDLE:
  - `start_i` with `len_i != 0`: latch beats = ceil(len/VECT_WIDTH) and rem = len mod VECT_WIDTH, go to LOAD_SCAL.
  - `start_i` with `len_i == 0`: pulse `done_o` next cycle, stay in IDLE.
- LOAD_SCAL: `scal_ready_o = 1`. On the scalar handshake, register `scal_i` into `req_scal_o` and go to ISSUE.
- ISSUE:
  - `req_valid_o = in_valid_i & credit_ok`, where credit_ok = outstanding < MAX_OUTSTANDING.
  - `in_ready_o = req_ready_i & credit_ok`.
  - `req_vect_o = in_data_i` (combinational pass-through).
  - `req_strb_o` is all ones, except on the last beat with rem != 0, where only the low rem bits are set.
  - `req_tag_o = 1` on the last beat only.
  - The last-beat handshake moves to DRAIN. If the last response also handshakes in that same cycle, go straight to IDLE.
- DRAIN: no new requests. The last-tagged response handshake moves to IDLE and schedules `done_o`.
- `req_scal_valid_o = 1` in ISSUE and DRAIN.
- Response path is combinational pass-through:
  - `out_valid_o = rsp_valid_i`, `rsp_ready_o = out_ready_i`.
  - Data and strobe pass through unchanged; `out_last_o = rsp_tag_i`.
- Outstanding counter: +1 on a request handshake, -1 on a response handshake. Both in one cycle leaves it unchanged. It is never below 0 or above MAX_OUTSTANDING.
- `start_i` outside IDLE is ignored.
- `busy_o = (state != IDLE)`.
- `clear_i`: returns to IDLE, zeroes all counters, no `done_o`, drops any pending `done_o`.

## Timing
- Reset and clear values:
  - State is IDLE.
  - All counters are 0 and `req_scal_o` is 0.
  - `busy_o`, `done_o`, `scal_ready_o`, `in_ready_o` and `req_valid_o` are 0.
  - `req_scal_valid_o` is 0; `req_tag_o` and `req_strb_o` are 0.
- The `in` to `req` and `rsp` to `out` paths have zero added latency.
- `done_o` is registered. It rises 1 cycle after the final `out` handshake, and 1 cycle after `start_i` when `len_i == 0`.
- The first request can be valid 1 cycle after the scalar handshake.
- Valid must not depend on ready on any interface this block drives. Once asserted, `req_valid_o` holds until handshake, provided `in_valid_i` obeys the same rule.
- A reset asserted mid-job takes effect at the next edge and behaves as reset. Any in-flight responses arriving afterwards are passed out but do not affect the FSM.

## Structure
- `softex_pkg` additions:
  - `issuer_state_t` enum for the FSM states.
  - `ISSUER_TAG_LAST` constant.
- Natural sub-module: `softex_credit_counter`, parameterised by MAX, with inc/dec inputs and `full`/`empty` outputs. It is reusable by other datapath initiators.
- Target size is about 200 lines of RTL.

## Test plan
- `VECT_WIDTH=4`, `len=10`, scalar 0x3C00, `req_ready` and `out_ready` held high, zero-latency responder:
  - 3 beats issued, strobes 1111, 1111, 0011; tag only on beat 3.
  - `out_last_o` on the 3rd output; `done_o` pulses once.
- `len=0` start: `done_o` one cycle later, no `scal_ready_o`, `busy_o` stays 0.
- `MAX_OUTSTANDING=2`, responder that never answers:
  - Exactly 2 requests handshake, then `in_ready_o = 0`.
  - Releasing one response allows exactly one more request.
- Random backpressure on `req_ready_i` and `out_ready_i` with `len=37`, `VECT_WIDTH=4`:
  - Output data equals input data in order, with 10 outputs.
  - The outstanding counter never exceeds its limit.
- `clear_i` asserted in the middle of ISSUE: next cycle `busy_o = 0`, no `done_o`; a new start with `len=4` completes normally.
- `start_i` pulsed during DRAIN: ignored; exactly one `done_o` for the original job.
